window_scan_engine: RTL and testbench
=====================================

Name: window_scan_engine

Overview:
- Parametrised successor to the binary median-filter window scanner.
- Walks a KxK window over an image held in external pixel memory, with runtime-configured dimensions, step and border mode. Issues read addresses under a valid/ready handshake.
- Re-aligns the returned memory data to per-window tags (first/last/centre) after a fixed read latency.
- Feeds the downstream median/sort core; sits between the frame buffer read port and that core.

Parameters:
- WINDOW_SIZE, 3, window edge K (odd, 3..7)
- PIXEL_W, 8, pixel data width (1 = binary image)
- COORD_W, 8, coordinate width (max image dim 2^COORD_W)
- READ_LATENCY, 2, cycles from accepted read to rd_data valid (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a frame scan (sampled in IDLE only)
- abort  in  1  cancel the scan in progress
- cfg_width  in  COORD_W  image width W
- cfg_height  in  COORD_W  image height H
- cfg_step  in  COORD_W  window step S
- cfg_mode  in  1  0 = VALID (window fully inside), 1 = REPLICATE (edge clamp)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, frame complete
- cfg_error  out  1  one-cycle pulse, start rejected
- rd_valid  out  1  read request valid
- rd_ready  in  1  memory accepts the request
- rd_x  out  COORD_W  read column
- rd_y  out  COORD_W  read row
- rd_data  in  PIXEL_W  pixel returned READ_LATENCY cycles after acceptance
- pix_valid  out  1  pix_data valid
- pix_data  out  PIXEL_W  window pixel
- pix_first  out  1  first pixel of a window
- pix_last  out  1  last (K*K-th) pixel of a window
- center_x  out  COORD_W  window centre column, valid with pix_valid
- center_y  out  COORD_W  window centre row, valid with pix_valid

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - Counters and tag pipeline are cleared.
- States:
  - IDLE -> SCAN on start with valid config. The config is latched that cycle; later config changes are ignored.
  - IDLE stays IDLE with a cfg_error pulse when the config is invalid: S==0, W==0, H==0, or in VALID mode W<K or H<K.
  - SCAN -> DRAIN when the final request is accepted.
  - DRAIN -> IDLE once the tag pipeline is empty. done pulses in the same cycle as the final pix_valid/pix_last.
- Scan order:
  - j (x offset 0..K-1) is fastest, then i (y offset), then origin x by S, then origin y by S.
- VALID mode:
  - Origin x runs 0, S, ... <= W-K; origin y likewise against H-K.
  - rd = origin + (j,i); centre = origin + K/2.
- REPLICATE mode:
  - Centre x runs 0, S, ... <= W-1; centre y likewise against H-1.
  - rd = clamp(centre + offset - K/2, 0, W-1 / H-1).
  - Clamp arithmetic uses COORD_W+1 signed width; no wrap-around.
- Counter advance: an origin step that would exceed its bound ends the row/frame. There is no partial window.
- Handshake:
  - A request transfers when rd_valid && rd_ready.
  - rd_x, rd_y and rd_valid hold stable while rd_ready==0.
  - Counters advance only on transfer.
  - rd_valid is high throughout SCAN, apart from reset/abort.
- Tag pipeline:
  - READ_LATENCY-deep shift register of {valid, first, last, cx, cy}, loaded on transfer.
  - The output stage combines the tag with rd_data, so pix_valid fires exactly READ_LATENCY cycles after its transfer.
  - No downstream backpressure: the consumer must accept every pixel.
- Abort (any non-IDLE state):
  - Next state is IDLE and rd_valid drops the next cycle.
  - All pipeline tags are invalidated; no further pix_valid for that frame.
  - done is not asserted.
  - abort in IDLE is ignored.
  - abort and start in the same cycle: abort wins and the start is dropped.
- start while busy is ignored.
- Reset mid-scan has the same effect as abort, plus it clears all outputs.

Decomposition:
- Shared package window_scan_pkg:
  - state enum {IDLE, SCAN, DRAIN}
  - mode constants MODE_VALID/MODE_REPLICATE
  - tag struct {valid, first, last, cx, cy}
  - localparam HALF = WINDOW_SIZE/2
- One sub-module: window_tag_pipe, the parametrised READ_LATENCY delay line with a synchronous flush input. The address counters and FSM stay in the top module.

Test Plan:
- K=3, W=5, H=4, S=1, VALID, rd_ready=1 -> 6 windows, 54 transfers. First rd (0,0), last rd (4,3). First centre (1,1), last centre (3,2). done coincides with the 54th pix_valid.
- K=3, W=4, H=4, S=1, REPLICATE -> 16 windows. Window 0 reads (0,0),(0,0),(1,0),(0,0),(0,0),(1,0),(0,1),(0,1),(1,1). Window 15 clamps to (3,3).
- VALID, W=7, H=7, S=2 -> origins x,y in {0,2,4} giving 9 windows. Centres (1,1)..(5,5). The origin step to 6 (>4) ends the row.
- Random rd_ready with 40% stalls -> rd_x/rd_y stable during stalls. pix_data matches a model memory; pix_first/pix_last every 9 pixels; done count = 1.
- Abort after 20 transfers with READ_LATENCY=3 -> no pix_valid after the abort cycle, busy=0 next cycle, no done. A following start rescans from (0,0).
- start with W=2, VALID, K=3 -> cfg_error pulse, busy stays 0, no rd_valid. Same config in REPLICATE -> scan proceeds (4 windows at H=2).

Source files
------------

// File: rtl/window_scan_pkg.sv
// Shared types and constants for the window scan engine and its tag delay line.
package window_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  localparam logic MODE_VALID     = 1'b0;
  localparam logic MODE_REPLICATE = 1'b1;

  localparam int unsigned DEFAULT_WINDOW_SIZE = 3;
  localparam int unsigned HALF                = DEFAULT_WINDOW_SIZE / 2;

  // Window offsets (K <= 7) fit in 3 bits; tag coordinates are carried at the widest supported width.
  localparam int unsigned OFS_W       = 3;
  localparam int unsigned MAX_COORD_W = 16;

  typedef struct packed {
    logic                   valid;
    logic                   first;
    logic                   last;
    logic [MAX_COORD_W-1:0] cx;
    logic [MAX_COORD_W-1:0] cy;
  } tag_t;

  function automatic int unsigned half_of(input int unsigned k);
    return k / 2;
  endfunction

endpackage

// File: rtl/window_scan_engine_tag_pipe.sv
// Fixed-depth delay line carrying per-request window tags until the matching read data returns.
module window_tag_pipe
  import window_scan_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  tag_t in_tag,
  output tag_t out_tag,
  output logic pending
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  always_comb begin
    for (int unsigned s = 0; s < DEPTH; s++) begin
      stage_d[s] = '0;
    end
    if (!flush) begin
      stage_d[0] = in_tag.valid ? in_tag : '0;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        stage_d[s] = stage_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  // Only stages still upstream of the output count as outstanding work.
  always_comb begin
    pending = 1'b0;
    for (int unsigned s = 0; s + 1 < DEPTH; s++) begin
      pending = pending | stage_q[s].valid;
    end
  end

  always_comb begin
    out_tag = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/window_scan_engine.sv
// KxK window address generator over an external pixel memory, re-tagging returned
// read data with window first/last/centre information after a fixed read latency.
module window_scan_engine
  import window_scan_pkg::*;
#(
  parameter int unsigned WINDOW_SIZE  = 3,
  parameter int unsigned PIXEL_W      = 8,
  parameter int unsigned COORD_W      = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  input  logic [COORD_W-1:0] cfg_step,
  input  logic               cfg_mode,
  output logic               busy,
  output logic               done,
  output logic               cfg_error,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  logic [PIXEL_W-1:0] rd_data,
  output logic               pix_valid,
  output logic [PIXEL_W-1:0] pix_data,
  output logic               pix_first,
  output logic               pix_last,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y
);

  localparam int unsigned        WIN_HALF = half_of(WINDOW_SIZE);
  localparam logic [OFS_W-1:0]   K_LAST   = OFS_W'(WINDOW_SIZE - 1);
  localparam logic [COORD_W-1:0] K_COORD  = COORD_W'(WINDOW_SIZE);

  typedef logic signed [COORD_W+1:0] sc_t;

  state_t             state_q, state_d;
  logic [OFS_W-1:0]   j_q, j_d, i_q, i_d;
  logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [COORD_W-1:0] xlim_q, xlim_d, ylim_q, ylim_d;
  logic [COORD_W-1:0] xmax_q, xmax_d, ymax_q, ymax_d;
  logic [COORD_W-1:0] step_q, step_d;
  logic               mode_q, mode_d;

  logic               cfg_ok, start_ok, xfer, last_req, flush, pipe_pending;
  logic [COORD_W:0]   ox_next, oy_next;
  sc_t                raw_x, raw_y;
  logic [COORD_W-1:0] addr_x, addr_y, cen_x, cen_y;
  tag_t               tag_in, tag_out;

  always_comb begin
    cfg_ok = (cfg_step != '0) && (cfg_width != '0) && (cfg_height != '0);
    if ((cfg_mode == MODE_VALID) && ((cfg_width < K_COORD) || (cfg_height < K_COORD))) begin
      cfg_ok = 1'b0;
    end
  end

  assign start_ok = start && !abort && cfg_ok;
  assign xfer     = (state_q == SCAN) && rd_ready;
  assign flush    = abort && (state_q != IDLE);

  always_comb begin
    ox_next  = {1'b0, ox_q} + {1'b0, step_q};
    oy_next  = {1'b0, oy_q} + {1'b0, step_q};
    last_req = (j_q == K_LAST) && (i_q == K_LAST) &&
               (ox_next > {1'b0, xlim_q}) && (oy_next > {1'b0, ylim_q});
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = SCAN;
      SCAN: begin
        if (abort)                 state_d = IDLE;
        else if (xfer && last_req) state_d = DRAIN;
      end
      DRAIN:   if (abort || !pipe_pending) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q != IDLE);
    rd_valid  = (state_q == SCAN);
    done      = (state_q == DRAIN) && !abort && tag_out.valid && tag_out.last && !pipe_pending;
    cfg_error = reset && (state_q == IDLE) && start && !abort && !cfg_ok;
  end

  // Origin/centre counters: j fastest, then i, then x origin, then y origin.
  always_comb begin
    j_d    = j_q;
    i_d    = i_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    xlim_d = xlim_q;
    ylim_d = ylim_q;
    xmax_d = xmax_q;
    ymax_d = ymax_q;
    step_d = step_q;
    mode_d = mode_q;
    if (state_q == IDLE) begin
      if (start_ok) begin
        j_d    = '0;
        i_d    = '0;
        ox_d   = '0;
        oy_d   = '0;
        xmax_d = cfg_width - COORD_W'(1);
        ymax_d = cfg_height - COORD_W'(1);
        xlim_d = cfg_mode ? cfg_width - COORD_W'(1) : cfg_width - K_COORD;
        ylim_d = cfg_mode ? cfg_height - COORD_W'(1) : cfg_height - K_COORD;
        step_d = cfg_step;
        mode_d = cfg_mode;
      end
    end else if (xfer) begin
      if (j_q != K_LAST) begin
        j_d = j_q + OFS_W'(1);
      end else begin
        j_d = '0;
        if (i_q != K_LAST) begin
          i_d = i_q + OFS_W'(1);
        end else begin
          i_d = '0;
          if (ox_next <= {1'b0, xlim_q}) begin
            ox_d = ox_next[COORD_W-1:0];
          end else begin
            ox_d = '0;
            if (oy_next <= {1'b0, ylim_q}) oy_d = oy_next[COORD_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      j_q    <= '0;
      i_q    <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      xlim_q <= '0;
      ylim_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
      step_q <= '0;
      mode_q <= MODE_VALID;
    end else begin
      j_q    <= j_d;
      i_q    <= i_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      xlim_q <= xlim_d;
      ylim_q <= ylim_d;
      xmax_q <= xmax_d;
      ymax_q <= ymax_d;
      step_q <= step_d;
      mode_q <= mode_d;
    end
  end

  // One signed clamp serves both modes: VALID never leaves the image, REPLICATE is offset by K/2.
  always_comb begin
    raw_x = sc_t'(ox_q) + sc_t'(j_q) - (mode_q ? sc_t'(WIN_HALF) : sc_t'(0));
    raw_y = sc_t'(oy_q) + sc_t'(i_q) - (mode_q ? sc_t'(WIN_HALF) : sc_t'(0));
    if (raw_x < 0)                   addr_x = '0;
    else if (raw_x > sc_t'(xmax_q))  addr_x = xmax_q;
    else                             addr_x = raw_x[COORD_W-1:0];
    if (raw_y < 0)                   addr_y = '0;
    else if (raw_y > sc_t'(ymax_q))  addr_y = ymax_q;
    else                             addr_y = raw_y[COORD_W-1:0];
    cen_x = mode_q ? ox_q : ox_q + COORD_W'(WIN_HALF);
    cen_y = mode_q ? oy_q : oy_q + COORD_W'(WIN_HALF);
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = xfer;
    tag_in.first = (j_q == '0) && (i_q == '0);
    tag_in.last  = (j_q == K_LAST) && (i_q == K_LAST);
    tag_in.cx    = MAX_COORD_W'(cen_x);
    tag_in.cy    = MAX_COORD_W'(cen_y);
  end

  window_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .in_tag (tag_in),
    .out_tag(tag_out),
    .pending(pipe_pending)
  );

  if (COORD_W < MAX_COORD_W) begin : g_tag_pad
    logic unused_tag_bits;
    always_comb begin
      unused_tag_bits = ^{tag_out.cx[MAX_COORD_W-1:COORD_W], tag_out.cy[MAX_COORD_W-1:COORD_W]};
    end
  end

  always_comb begin
    rd_x      = rd_valid ? addr_x : '0;
    rd_y      = rd_valid ? addr_y : '0;
    pix_valid = tag_out.valid;
    pix_data  = tag_out.valid ? rd_data : '0;
    pix_first = tag_out.first;
    pix_last  = tag_out.last;
    center_x  = tag_out.cx[COORD_W-1:0];
    center_y  = tag_out.cy[COORD_W-1:0];
  end

endmodule

// File: tb/tb_window_scan_engine.sv
// Directed self-checking bench for window_scan_engine (K=3, 8-bit coords, read latency 3).
module tb_window_scan_engine;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       reset, start, abort, cfg_mode, rd_ready;
  logic [7:0] cfg_width, cfg_height, cfg_step;
  logic       busy, done, cfg_error, rd_valid, pix_valid, pix_first, pix_last;
  logic [7:0] rd_x, rd_y, rd_data, pix_data, center_x, center_y;

  window_scan_engine #(
    .WINDOW_SIZE (3),
    .PIXEL_W     (8),
    .COORD_W     (8),
    .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_step(cfg_step), .cfg_mode(cfg_mode),
    .busy(busy), .done(done), .cfg_error(cfg_error),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_first(pix_first), .pix_last(pix_last),
    .center_x(center_x), .center_y(center_y)
  );

  always #5 clk = ~clk;

  function automatic int pix_of(input int x, input int y);
    return (x * 7 + y * 13 + 5) & 255;
  endfunction

  // Memory model: data for an accepted read appears LAT cycles later.
  logic [7:0] mem_d [LAT];
  always @(posedge clk) begin
    mem_d[0] <= (rd_valid && rd_ready) ? 8'(pix_of(int'(rd_x), int'(rd_y))) : 8'h00;
    for (int s = 1; s < LAT; s++) mem_d[s] <= mem_d[s-1];
  end
  assign rd_data = mem_d[LAT-1];

  // Monitor, sampled on the falling edge.
  logic mon_clr = 1'b1, mon_post = 1'b0;
  int n_rq, n_pix, n_done, done_idx, n_post, n_cfgerr, n_rdv, stall_viol, cyc_cnt = 0;
  int done_ok, prev_stall, prev_x, prev_y;
  int rq_x[256], rq_y[256], rq_t[256];
  int px_d[256], px_f[256], px_l[256], px_cx[256], px_cy[256], px_t[256];

  always @(negedge clk) begin
    cyc_cnt++;
    if (mon_clr) begin
      n_rq = 0; n_pix = 0; n_done = 0; done_idx = -1; n_post = 0; n_cfgerr = 0;
      n_rdv = 0; stall_viol = 0; done_ok = 0; prev_stall = 0; prev_x = 0; prev_y = 0;
    end else begin
      if (prev_stall != 0 && !(rd_valid && int'(rd_x) == prev_x && int'(rd_y) == prev_y))
        stall_viol++;
      prev_stall = (rd_valid && !rd_ready) ? 1 : 0;
      prev_x = int'(rd_x);
      prev_y = int'(rd_y);
      if (rd_valid) n_rdv++;
      if (cfg_error) n_cfgerr++;
      if (rd_valid && rd_ready) begin
        if (n_rq < 256) begin
          rq_x[n_rq] = int'(rd_x); rq_y[n_rq] = int'(rd_y); rq_t[n_rq] = cyc_cnt;
        end
        n_rq++;
      end
      if (pix_valid) begin
        if (n_pix < 256) begin
          px_d[n_pix] = int'(pix_data); px_f[n_pix] = int'(pix_first); px_l[n_pix] = int'(pix_last);
          px_cx[n_pix] = int'(center_x); px_cy[n_pix] = int'(center_y); px_t[n_pix] = cyc_cnt;
        end
        n_pix++;
        if (mon_post) n_post++;
      end
      if (done) begin
        n_done++;
        done_idx = n_pix;
        done_ok  = (pix_valid && pix_last) ? 1 : 0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  typedef struct {
    int x, y, cx, cy, first, last;
  } exp_t;
  exp_t exp_q[$];

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic build_exp(input int w, input int h, input int s, input bit mode);
    exp_t e;
    exp_q.delete();
    if (!mode) begin
      for (int oy = 0; oy <= h - 3; oy += s)
        for (int ox = 0; ox <= w - 3; ox += s)
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              e.x = ox + j; e.y = oy + i; e.cx = ox + 1; e.cy = oy + 1;
              e.first = (i == 0 && j == 0) ? 1 : 0; e.last = (i == 2 && j == 2) ? 1 : 0;
              exp_q.push_back(e);
            end
    end else begin
      for (int cy = 0; cy <= h - 1; cy += s)
        for (int cx = 0; cx <= w - 1; cx += s)
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              e.x = clampi(cx + j - 1, w - 1); e.y = clampi(cy + i - 1, h - 1);
              e.cx = cx; e.cy = cy;
              e.first = (i == 0 && j == 0) ? 1 : 0; e.last = (i == 2 && j == 2) ? 1 : 0;
              exp_q.push_back(e);
            end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    mon_post = 1'b0;
    step();
    mon_clr = 1'b0;
  endtask

  // Starts a frame, then changes the config inputs to prove they were latched.
  task automatic run_frame(input int w, input int h, input int s, input bit mode, input bit stall);
    int cyc;
    build_exp(w, h, s, mode);
    clear_mon();
    cfg_width = 8'(w); cfg_height = 8'(h); cfg_step = 8'(s); cfg_mode = mode;
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_width = 8'd1; cfg_height = 8'd1; cfg_step = 8'd9; cfg_mode = ~mode;
    cyc = 0;
    while (busy && cyc < 5000) begin
      rd_ready = stall ? ($urandom_range(0, 99) >= 40) : 1'b1;
      step();
      cyc++;
    end
    rd_ready = 1'b1;
    check("frame_end_busy", busy, 0);
    repeat (2) step();
  endtask

  task automatic verify(input string nm);
    int n;
    n = exp_q.size();
    check({nm, ".n_rq"}, n_rq, n);
    check({nm, ".n_pix"}, n_pix, n);
    check({nm, ".n_done"}, n_done, 1);
    check({nm, ".done_with_last"}, done_ok, 1);
    check({nm, ".done_idx"}, done_idx, n);
    check({nm, ".stall_stable"}, stall_viol, 0);
    for (int k = 0; k < n && k < 256; k++) begin
      check($sformatf("%s.rd_x[%0d]", nm, k), rq_x[k], exp_q[k].x);
      check($sformatf("%s.rd_y[%0d]", nm, k), rq_y[k], exp_q[k].y);
      check($sformatf("%s.data[%0d]", nm, k), px_d[k], pix_of(exp_q[k].x, exp_q[k].y));
      check($sformatf("%s.first[%0d]", nm, k), px_f[k], exp_q[k].first);
      check($sformatf("%s.last[%0d]", nm, k), px_l[k], exp_q[k].last);
      check($sformatf("%s.cx[%0d]", nm, k), px_cx[k], exp_q[k].cx);
      check($sformatf("%s.cy[%0d]", nm, k), px_cy[k], exp_q[k].cy);
      check($sformatf("%s.latency[%0d]", nm, k), px_t[k] - rq_t[k], LAT);
    end
  endtask

  int wx[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
  int wy[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    int cyc;
    reset = 1'b0; start = 1'b0; abort = 1'b0; rd_ready = 1'b1;
    cfg_width = '0; cfg_height = '0; cfg_step = '0; cfg_mode = 1'b0;
    repeat (3) step();
    check("rst.busy", busy, 0);
    check("rst.rd_valid", rd_valid, 0);
    check("rst.pix_valid", pix_valid, 0);
    check("rst.done", done, 0);
    check("rst.cfg_error", cfg_error, 0);
    check("rst.rd_x", rd_x, 0);
    check("rst.center_x", center_x, 0);
    reset = 1'b1;
    step();

    // VALID 5x4 step 1: 6 windows
    run_frame(5, 4, 1, 1'b0, 1'b0);
    verify("valid5x4");
    check("valid5x4.n_rq_hand", n_rq, 54);
    check("valid5x4.first_rd", {rq_x[0][15:0], rq_y[0][15:0]}, {16'd0, 16'd0});
    check("valid5x4.last_rd", {rq_x[53][15:0], rq_y[53][15:0]}, {16'd4, 16'd3});
    check("valid5x4.first_ctr", {px_cx[0][15:0], px_cy[0][15:0]}, {16'd1, 16'd1});
    check("valid5x4.last_ctr", {px_cx[53][15:0], px_cy[53][15:0]}, {16'd3, 16'd2});

    // REPLICATE 4x4 step 1: 16 windows with edge clamping
    run_frame(4, 4, 1, 1'b1, 1'b0);
    verify("repl4x4");
    check("repl4x4.n_rq_hand", n_rq, 144);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("repl4x4.w0_x[%0d]", k), rq_x[k], wx[k]);
      check($sformatf("repl4x4.w0_y[%0d]", k), rq_y[k], wy[k]);
    end
    check("repl4x4.last_rd", {rq_x[143][15:0], rq_y[143][15:0]}, {16'd3, 16'd3});
    check("repl4x4.last_ctr", {px_cx[143][15:0], px_cy[143][15:0]}, {16'd3, 16'd3});

    // VALID 7x7 step 2: origins {0,2,4}
    run_frame(7, 7, 2, 1'b0, 1'b0);
    verify("valid7x7s2");
    check("valid7x7s2.n_rq_hand", n_rq, 81);
    check("valid7x7s2.ctr_w0", {px_cx[0][15:0], px_cy[0][15:0]}, {16'd1, 16'd1});
    check("valid7x7s2.ctr_w2", {px_cx[18][15:0], px_cy[18][15:0]}, {16'd5, 16'd1});
    check("valid7x7s2.ctr_w3", {px_cx[27][15:0], px_cy[27][15:0]}, {16'd1, 16'd3});
    check("valid7x7s2.ctr_w8", {px_cx[80][15:0], px_cy[80][15:0]}, {16'd5, 16'd5});

    // Random 40% stalls on the read port
    run_frame(5, 4, 1, 1'b0, 1'b1);
    verify("stall5x4");

    // Abort after 20 transfers
    clear_mon();
    cfg_width = 8'd7; cfg_height = 8'd7; cfg_step = 8'd1; cfg_mode = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (n_rq < 20 && cyc < 200) begin
      step();
      cyc++;
    end
    check("abort.reach20", n_rq, 20);
    abort = 1'b1;
    step();
    abort = 1'b0;
    mon_post = 1'b1;
    check("abort.busy_next", busy, 0);
    check("abort.rd_valid_next", rd_valid, 0);
    repeat (10) step();
    check("abort.no_pix_after", n_post, 0);
    check("abort.no_done", n_done, 0);
    check("abort.idle", busy, 0);

    // Rescan after abort starts from the origin
    run_frame(5, 4, 1, 1'b0, 1'b0);
    verify("rescan");

    // Abort together with start in IDLE: start dropped
    cfg_width = 8'd5; cfg_height = 8'd4; cfg_step = 8'd1; cfg_mode = 1'b0;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start.busy", busy, 0);
    step();
    check("abort_start.busy2", busy, 0);

    // Invalid config: W<K in VALID mode
    clear_mon();
    cfg_width = 8'd2; cfg_height = 8'd2; cfg_step = 8'd1; cfg_mode = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("cfgerr.busy", busy, 0);
    repeat (3) step();
    check("cfgerr.pulses", n_cfgerr, 1);
    check("cfgerr.no_rd_valid", n_rdv, 0);
    check("cfgerr.busy_after", busy, 0);

    // Same geometry in REPLICATE is accepted: 4 windows
    run_frame(2, 2, 1, 1'b1, 1'b0);
    verify("repl2x2");
    check("repl2x2.n_rq_hand", n_rq, 36);
    check("repl2x2.no_cfgerr", n_cfgerr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
